wallace_arbiter: RTL and testbench

WALLACE_ARBITER -- requirements
Module: wallace_arbiter

---
 rtl/wallace_arbiter_pkg.sv | 16 +
 rtl/wallace_arbiter_wallace.sv | 20 ++
 rtl/wallace_arbiter.sv | 108 ++++++++++
 tb/tb_wallace_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/wallace_arbiter_pkg.sv
// Shared constants and the operand-stage record for the time-shared multiplier.
// The id field is sized for the largest legal requester count (8).
package wallace_arbiter_pkg;

    localparam int MUL_W   = 8;
    localparam int PROD_W  = 16;
    localparam int ID_MAXW = 3;

    typedef struct packed {
        logic               valid;
        logic [MUL_W-1:0]   a;
        logic [MUL_W-1:0]   b;
        logic [ID_MAXW-1:0] id;
    } s1_t;

endpackage

// File: rtl/wallace_arbiter_wallace.sv
// 8x8 unsigned combinational multiplier.
// Forms one shifted partial product per multiplier bit and sums them.
module wallace
    import wallace_arbiter_pkg::*;
(
    input  logic [MUL_W-1:0]  a,
    input  logic [MUL_W-1:0]  b,
    output logic [PROD_W-1:0] product
);

    always_comb begin
        product = '0;
        for (int i = 0; i < MUL_W; i++) begin
            if (b[i]) begin
                product = product + (PROD_W'(a) << i);
            end
        end
    end

endmodule

// File: rtl/wallace_arbiter.sv
// Round-robin arbiter sharing one multiplier across NREQ requesters.
// Two-stage pipeline: S1 holds operands, S2 holds the product and drives rsp.
module wallace_arbiter
    import wallace_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_product,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       done_count
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; ready never depends on the same-side valid's history.
    s1_t               s1;
    logic              s2_valid;
    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    grant_id;
    logic              found;
    logic [NREQ-1:0]   grant;
    logic              rsp_fire;
    logic              s1_adv;
    logic              s1_can_load;
    logic              accept;
    logic [PROD_W-1:0] mul_out;
    int                idx;

    assign rsp_valid   = s2_valid;
    assign rsp_fire    = s2_valid & rsp_ready;
    assign s1_adv      = s1.valid & (~s2_valid | rsp_fire);
    assign s1_can_load = ~s1.valid | s1_adv;
    assign req_ready   = grant;
    assign accept      = |(req_valid & grant);

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                grant_id = IDW'(idx);
            end
        end
        // Reset gating keeps the grant quiet while rst is held.
        if (found && s1_can_load && !rst) begin
            grant[grant_id] = 1'b1;
        end
    end

    wallace u_wallace (
        .a       (s1.a),
        .b       (s1.b),
        .product (mul_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1          <= '0;
            s2_valid    <= 1'b0;
            rsp_product <= '0;
            rsp_id      <= '0;
            ptr         <= '0;
            done_count  <= '0;
        end else begin
            if (s1_adv) begin
                s2_valid    <= 1'b1;
                rsp_product <= mul_out;
                rsp_id      <= s1.id[IDW-1:0];
            end else if (rsp_fire) begin
                s2_valid <= 1'b0;
            end

            if (accept) begin
                s1.valid <= 1'b1;
                s1.a     <= req_a[int'(grant_id)*MUL_W +: MUL_W];
                s1.b     <= req_b[int'(grant_id)*MUL_W +: MUL_W];
                s1.id    <= ID_MAXW'(grant_id);
                if (int'(grant_id) == NREQ - 1) begin
                    ptr <= '0;
                end else begin
                    ptr <= grant_id + 1'b1;
                end
            end else if (s1_adv) begin
                s1.valid <= 1'b0;
            end

            if (rsp_fire) begin
                done_count <= done_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_wallace_arbiter.sv
// Bench for wallace_arbiter: random and directed traffic against a queue model
// that tracks accepted operands by age rather than by pipeline stage.
module tb_wallace_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int PW   = 16 + IDW;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_a;
    logic [NREQ*8-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_product;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       done_count;

    wallace_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .rsp_id      (rsp_id),
        .done_count  (done_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: {id, product} per accepted operand, oldest first
    logic [PW-1:0] exp_q[$];
    int            age_q[$];
    int            m_ptr;
    int            m_done;
    int            n_accept;
    int            checks;
    int            errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, checks outputs against the model, then
    // advances the model to what the coming edge must do.
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*8-1:0] a,
                        input logic [NREQ*8-1:0] b, input logic rdy);
        logic          front_ok;
        logic          fire;
        logic          can_load;
        int            g;
        logic [NREQ-1:0] exp_ready;
        logic [PW-1:0] f;
        int            ai;
        int            bi;
        @(negedge clk);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = rdy;
        #1;
        front_ok = (exp_q.size() > 0) && (age_q[0] >= 2);
        check("rsp_valid", 32'(rsp_valid), 32'(front_ok));
        if (front_ok) begin
            f = exp_q[0];
            check("rsp_product", 32'(rsp_product), 32'(f[15:0]));
            check("rsp_id", 32'(rsp_id), 32'(f[PW-1:16]));
        end
        check("done_count", 32'(done_count), 32'(m_done % 65536));
        fire     = front_ok && rdy;
        can_load = (exp_q.size() < 2) || fire;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        end
        exp_ready = '0;
        if (g >= 0 && can_load) exp_ready[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        if (fire) begin
            void'(exp_q.pop_front());
            void'(age_q.pop_front());
            m_done++;
        end
        foreach (age_q[i]) age_q[i]++;
        if (g >= 0 && can_load) begin
            ai = int'(a[g*8 +: 8]);
            bi = int'(b[g*8 +: 8]);
            exp_q.push_back({IDW'(g), 16'(ai * bi)});
            age_q.push_back(1);
            m_ptr = (g + 1) % NREQ;
            n_accept++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_product", 32'(rsp_product), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_done_count", 32'(done_count), 32'd0);
        exp_q.delete();
        age_q.delete();
        m_ptr  = 0;
        m_done = 0;
        @(negedge clk);
        req_valid = '0;
        rst       = 1'b0;
    endtask

    function automatic logic [7:0] rand_op();
        int s;
        s = int'($urandom_range(0, 9));
        if (s == 0) return 8'h00;
        if (s == 1) return 8'hFF;
        return 8'($urandom);
    endfunction

    initial begin
        logic [NREQ*8-1:0] va;
        logic [NREQ*8-1:0] vb;
        int cyc;
        checks = 0; errors = 0; m_ptr = 0; m_done = 0; n_accept = 0;
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        req_valid = 4'b1111;
        #1;
        check("hold_req_ready", 32'(req_ready), 32'd0);
        check("hold_rsp_valid", 32'(rsp_valid), 32'd0);
        check("hold_done_count", 32'(done_count), 32'd0);
        req_valid = '0;
        rst = 1'b0;

        // single request: 0x0C*0x0D from requester 0
        step(4'b0001, 32'h0000_000C, 32'h0000_000D, 1'b1);
        repeat (3) step('0, '0, '0, 1'b1);
        check("single_done", 32'(done_count), 32'd1);

        // all four continuously valid, full rate
        for (int c = 0; c < 12; c++) step(4'b1111, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd10, 8'd20, 8'd30, 8'd40}, 1'b1);
        repeat (3) step('0, '0, '0, 1'b1);

        // backpressure for 5 cycles with traffic pending, then release
        for (int c = 0; c < 3; c++) step(4'b1111, {8'h11, 8'h22, 8'h33, 8'h44}, {8'h55, 8'h66, 8'h77, 8'h88}, 1'b1);
        for (int c = 0; c < 5; c++) step(4'b1111, {8'h99, 8'hAA, 8'hBB, 8'hCC}, {8'h01, 8'h02, 8'h03, 8'h04}, 1'b0);
        repeat (6) step('0, '0, '0, 1'b1);

        // corner operands
        step(4'b0010, 32'h0000_FF00, 32'h0000_FF00, 1'b1);
        step(4'b1000, 32'h0000_0000, 32'hA500_0000, 1'b1);
        step('0, '0, '0, 1'b1);
        check("ff_times_ff", 32'(rsp_product), 32'h0000_FE01);
        step('0, '0, '0, 1'b1);
        check("zero_times_a5", 32'(rsp_product), 32'h0000_0000);
        repeat (2) step('0, '0, '0, 1'b1);

        // fill both stages, then reset mid-flight
        for (int c = 0; c < 4; c++) step(4'b1111, {8'd9, 8'd8, 8'd7, 8'd6}, {8'd5, 8'd4, 8'd3, 8'd2}, 1'b0);
        check("full_before_rst", 32'(exp_q.size()), 32'd2);
        req_valid = 4'b1111;
        do_reset();
        step(4'b0100, 32'h0037_0000, 32'h0041_0000, 1'b1);
        repeat (3) step('0, '0, '0, 1'b1);
        check("post_rst_done", 32'(done_count), 32'd1);

        // randomized traffic
        n_accept = 0;
        cyc = 0;
        while (n_accept < 10000 && cyc < 20000) begin
            for (int r = 0; r < NREQ; r++) begin
                va[r*8 +: 8] = rand_op();
                vb[r*8 +: 8] = rand_op();
            end
            step(4'($urandom_range(0, 15)), va, vb, $urandom_range(0, 9) != 0);
            cyc++;
        end
        check("random_budget", 32'(n_accept >= 10000), 32'd1);

        // run to just past the done_count wrap
        cyc = 0;
        while (m_done < 65537 && cyc < 70000) begin
            for (int r = 0; r < NREQ; r++) begin
                va[r*8 +: 8] = 8'($urandom);
                vb[r*8 +: 8] = 8'($urandom);
            end
            if (m_done >= 65535) step('0, va, vb, 1'b1);
            else step(4'b1111, va, vb, 1'b1);
            cyc++;
        end
        check("wrap_budget", 32'(m_done == 65537), 32'd1);
        step('0, '0, '0, 1'b1);
        check("wrap_value", 32'(done_count), 32'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
